mod4051_residue_accumulator: RTL and testbench

Streaming modular accumulator that consumes the 12-bit partial residues produced by the 6-input mod-4051 chunk LUTs. Each beat carries one chunk residue. The block sums the residues modulo 4051 over a frame and presents the reduced 12-bit residue of the whole wide operand. It sits directly downstream of the LUT bank and upstream of the modular arithmetic datapath.

---
 rtl/mod4051_pkg.sv | 16 +
 rtl/mod4051_residue_accumulator_if.sv | 30 +++
 rtl/mod4051_add.sv | 24 ++
 rtl/mod4051_residue_accumulator.sv | 130 +++++++++++++
 tb/tb_mod4051_residue_accumulator.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod4051_pkg.sv
// Shared types and constants for the mod-4051 residue datapath.
package mod4051_pkg;

  localparam int RES_W = 12;

  typedef logic [RES_W-1:0] res_t;

  localparam res_t MOD4051 = 12'd4051;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

endpackage

// File: rtl/mod4051_residue_accumulator_if.sv
// Beat stream in / frame result out bundle for the residue accumulator.
interface mod4051_residue_accumulator_if #(
  parameter int CNT_W = 7
);
  import mod4051_pkg::*;

  logic             in_valid;
  logic             in_ready;
  res_t             in_res;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  res_t             out_res;
  logic [CNT_W-1:0] out_beats;
  logic             out_ovf;
  logic             out_err;

  // Producer of beats / consumer of results.
  modport master (
    output in_valid, in_res, in_last, out_ready,
    input  in_ready, out_valid, out_res, out_beats, out_ovf, out_err
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_res, in_last, out_ready,
    output in_ready, out_valid, out_res, out_beats, out_ovf, out_err
  );

endinterface

// File: rtl/mod4051_add.sv
// Combinational modular adder: y = (a + b) mod 4051 for a, b < 4051.
module mod4051_add
  import mod4051_pkg::*;
(
  input  res_t a,
  input  res_t b,
  output res_t y
);

  logic [RES_W:0] sum;
  logic [RES_W:0] diff;

  // 13-bit sum so the carry is kept; subtract the modulus once if needed.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = sum - {1'b0, MOD4051};
    if (sum >= {1'b0, MOD4051}) begin
      y = diff[RES_W-1:0];
    end else begin
      y = sum[RES_W-1:0];
    end
  end

endmodule

// File: rtl/mod4051_residue_accumulator.sv
// Streaming mod-4051 frame accumulator.
// Optional feature: MOD4051_ACC_RANGE_CHECK_EN pre-reduces out-of-range
// residues and reports them through a sticky per-frame out_err flag.
module mod4051_residue_accumulator
  import mod4051_pkg::*;
#(
  parameter int MAX_BEATS = 84,
  parameter int CNT_W     = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  mod4051_residue_accumulator_if.slave bus
);

  acc_state_t       state;
  res_t             acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  res_t             operand;
  res_t             sum;
  logic             accept;
  logic             at_limit;
  logic             end_frame;
  logic             release_out;

  logic             out_valid_q;
  res_t             out_res_q;
  logic [CNT_W-1:0] out_beats_q;
  logic             out_ovf_q;

  // Readiness comes from registered state only; no path from out_ready.
  assign bus.in_ready = (state != HOLD);

  assign accept      = bus.in_valid & bus.in_ready;
  assign cnt_next    = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign at_limit    = (cnt_next == CNT_W'(MAX_BEATS));
  assign end_frame   = accept & (bus.in_last | at_limit);
  assign release_out = (state == HOLD) & bus.out_ready;

`ifdef MOD4051_ACC_RANGE_CHECK_EN
  logic bad_res;
  logic err_frame;
  logic out_err_q;

  // Fold a residue that slipped past the LUT range back below the modulus.
  always_comb begin
    bad_res = (bus.in_res >= MOD4051);
    if (bad_res) begin
      operand = bus.in_res - MOD4051;
    end else begin
      operand = bus.in_res;
    end
  end

  // Sticky error for the frame in progress, published alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_frame <= 1'b0;
      out_err_q <= 1'b0;
    end else if (end_frame) begin
      err_frame <= 1'b0;
      out_err_q <= err_frame | bad_res;
    end else if (accept) begin
      err_frame <= err_frame | bad_res;
    end else if (release_out) begin
      err_frame <= 1'b0;
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign operand     = bus.in_res;
  assign bus.out_err = 1'b0;
`endif

  mod4051_add u_add (
    .a (acc),
    .b (operand),
    .y (sum)
  );

  // Frame FSM with accumulator, beat counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= 12'd0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= 12'd0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (end_frame) begin
            out_valid_q <= 1'b1;
            out_res_q   <= sum;
            out_beats_q <= cnt_next;
            out_ovf_q   <= at_limit & ~bus.in_last;
            state       <= HOLD;
          end else if (accept) begin
            acc   <= sum;
            cnt   <= cnt_next;
            state <= ACC;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            acc         <= 12'd0;
            cnt         <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          acc         <= 12'd0;
          cnt         <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_beats = out_beats_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mod4051_residue_accumulator.sv
// Self-checking bench for mod4051_residue_accumulator.
module tb_mod4051_residue_accumulator;

  localparam int MAXB  = 84;
  localparam int CW    = 7;
  localparam int MODV  = 4051;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   frame_q[$];
  int   exp_res;
  int   exp_beats;
  bit   exp_ovf;
  bit   exp_err;

  mod4051_residue_accumulator_if #(.CNT_W(CW)) bus ();

  mod4051_residue_accumulator #(.MAX_BEATS(MAXB), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer sum of (pre-reduced) residues, then mod 4051.
  function automatic void model(input bit use_last);
    longint s;
    int v;
    s = 0;
    exp_err = 1'b0;
    for (int i = 0; i < frame_q.size(); i++) begin
      v = frame_q[i];
      if (v >= MODV) begin
        v = v - MODV;
        exp_err = 1'b1;
      end
      s = s + v;
    end
    exp_res   = int'(s % MODV);
    exp_beats = frame_q.size();
    exp_ovf   = (frame_q.size() == MAXB) && !use_last;
  endfunction

  task automatic send_beats(input bit use_last, input bit gaps);
    int wait_cnt;
    int n;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_res   = 12'(frame_q[i]);
      bus.in_last  = use_last && (i == n - 1);
      wait_cnt = 0;
      while (bus.in_ready !== 1'b1 && wait_cnt < 200) begin
        @(posedge clk); #1;
        wait_cnt++;
      end
      if (wait_cnt >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL in_ready_timeout: in_ready=%b required 1", bus.in_ready);
      end
      @(posedge clk); #1;
      if (gaps && i != n - 1 && $urandom_range(3, 0) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'($urandom_range(1, 0));
        bus.in_res   = 12'($urandom_range(4050, 0));
        repeat ($urandom_range(3, 1)) begin
          @(posedge clk); #1;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic handshake(input int stall);
    bus.out_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_res !== 12'd0) begin n_fail++; $display("FAIL reset_out_res: got %0d want 0", bus.out_res); end
    n_checks++; if (bus.out_beats !== 7'd0) begin n_fail++; $display("FAIL reset_out_beats: got %0d want 0", bus.out_beats); end
    n_checks++; if (bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", bus.out_ovf); end
    n_checks++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
  endtask

  task automatic test_wrap();
    frame_q = '{4050, 1};
    model(1'b1);
    send_beats(1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_latency: out_valid=%b want 1", bus.out_valid); end
    n_checks++; if (bus.out_res !== 12'(exp_res)) begin n_fail++; $display("FAIL wrap_res: got %0d want %0d", bus.out_res, exp_res); end
    n_checks++; if (bus.out_beats !== 7'(exp_beats)) begin n_fail++; $display("FAIL wrap_beats: got %0d want %0d", bus.out_beats, exp_beats); end
    handshake(0);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    frame_q = '{2000, 2000, 100};
    model(1'b1);
    send_beats(1'b1, 1'b0);
    bus.out_ready = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_res !== 12'(exp_res)) begin n_fail++; $display("FAIL b2b_res: got %0d want %0d", bus.out_res, exp_res); end
    n_checks++; if (bus.out_beats !== 7'(exp_beats)) begin n_fail++; $display("FAIL b2b_beats: got %0d want %0d", bus.out_beats, exp_beats); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hold_ready: got %b want 0", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_res = 12'd7; bus.in_last = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: out_valid=%b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_hs: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_res !== 12'd7 || bus.out_beats !== 7'd1) begin
      n_fail++; $display("FAIL b2b_next_frame: valid=%b res=%0d beats=%0d want 1/7/1", bus.out_valid, bus.out_res, bus.out_beats);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    frame_q = '{1234};
    model(1'b1);
    send_beats(1'b1, 1'b0);
    bus.in_valid = 1'b1; bus.in_res = 12'd99; bus.in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_res !== 12'(exp_res) || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable[%0d]: valid=%b res=%0d ready=%b want 1/%0d/0", c, bus.out_valid, bus.out_res, bus.in_ready, exp_res);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: out_valid=%b want 0", bus.out_valid); end
    n_checks++; if (bus.out_res !== 12'(exp_res) || bus.out_beats !== 7'd1) begin
      n_fail++; $display("FAIL hold_keep_regs: res=%0d beats=%0d want %0d/1", bus.out_res, bus.out_beats, exp_res);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 2; k++) begin
      frame_q = {};
      for (int i = 0; i < MAXB; i++) frame_q.push_back(4050);
      model(k == 1);
      send_beats(k == 1, 1'b0);
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL limit_valid[%0d]: got %b want 1", k, bus.out_valid); end
      n_checks++; if (bus.out_ovf !== exp_ovf) begin n_fail++; $display("FAIL limit_ovf[%0d]: got %b want %b", k, bus.out_ovf, exp_ovf); end
      n_checks++; if (bus.out_beats !== 7'(exp_beats)) begin n_fail++; $display("FAIL limit_beats[%0d]: got %0d want %0d", k, bus.out_beats, exp_beats); end
      n_checks++; if (bus.out_res !== 12'(exp_res)) begin n_fail++; $display("FAIL limit_res[%0d]: got %0d want %0d", k, bus.out_res, exp_res); end
      handshake(1);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_q = '{11, 22, 33};
    send_beats(1'b0, 1'b0);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rst_discard[%0d]: valid=%b ready=%b want 0/1", c, bus.out_valid, bus.in_ready);
      end
    end
    frame_q = '{7};
    model(1'b1);
    send_beats(1'b1, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_res !== 12'(exp_res) || bus.out_beats !== 7'd1) begin
      n_fail++; $display("FAIL rst_next_frame: valid=%b res=%0d beats=%0d want 1/%0d/1", bus.out_valid, bus.out_res, bus.out_beats, exp_res);
    end
    handshake(0);
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(30, 1);
      frame_q = {};
      for (int i = 0; i < len; i++) begin
`ifdef MOD4051_ACC_RANGE_CHECK_EN
        frame_q.push_back($urandom_range(7, 0) == 0 ? $urandom_range(4095, 4051) : $urandom_range(4050, 0));
`else
        frame_q.push_back($urandom_range(4050, 0));
`endif
      end
      model(1'b1);
      send_beats(1'b1, 1'b1);
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want 1", f, bus.out_valid); end
      n_checks++; if (bus.out_res !== 12'(exp_res) || bus.out_beats !== 7'(exp_beats) || bus.out_ovf !== 1'b0) begin
        n_fail++; $display("FAIL rand_frame[%0d]: res=%0d beats=%0d ovf=%b want %0d/%0d/0", f, bus.out_res, bus.out_beats, bus.out_ovf, exp_res, exp_beats);
      end
      n_checks++; if (bus.out_err !== exp_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %b want %b", f, bus.out_err, exp_err); end
      handshake($urandom_range(3, 0));
    end
  endtask

`ifdef MOD4051_ACC_RANGE_CHECK_EN
  task automatic test_range_check();
    frame_q = '{4095, 10};
    model(1'b1);
    send_beats(1'b1, 1'b0);
    n_checks++; if (bus.out_res !== 12'(exp_res) || bus.out_err !== 1'b1) begin
      n_fail++; $display("FAIL range_bad: res=%0d err=%b want %0d/1", bus.out_res, bus.out_err, exp_res);
    end
    handshake(0);
    frame_q = '{5};
    model(1'b1);
    send_beats(1'b1, 1'b0);
    n_checks++; if (bus.out_res !== 12'd5 || bus.out_err !== 1'b0) begin
      n_fail++; $display("FAIL range_clear: res=%0d err=%b want 5/0", bus.out_res, bus.out_err);
    end
    handshake(0);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_res    = 12'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_wrap();
    test_back_to_back();
    test_hold();
    test_overflow();
    test_reset_mid_frame();
`ifdef MOD4051_ACC_RANGE_CHECK_EN
    test_range_check();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
